// File: rtl/mmu_bus_arb.sv
// mmu_bus_arb: two-requester Wishbone classic arbiter for the PMMU (0 = table walker, 1 = CPU path).
// Optional bus-cycle watchdog is enabled with `define MMU_ARB_WATCHDOG_EN.
`timescale 1ns/1ps
module mmu_bus_arb #(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_n,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_lock_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,

  output logic [1:0]  grant_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  if (STARVE_MAX < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("mmu_bus_arb: STARVE_MAX and TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          wdog_to;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Walker has priority except when the CPU path has waited out STARVE_MAX walker grants.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (starve_cnt == STARVE_LIM) begin
            state_nxt  = OWN1;
            starve_nxt = '0;
          end else begin
            state_nxt  = OWN0;
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_nxt = OWN0;
        end else if (m1_cyc_i) begin
          state_nxt  = OWN1;
          starve_nxt = '0;
        end
        if (!m1_cyc_i) begin
          starve_nxt = '0;
        end
      end
      OWN0: begin
        if (!m0_cyc_i && !m0_lock_i) begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wdog_to) begin
      state_nxt = IDLE;
    end
  end

  // Bus mux and termination routing; err wins over a simultaneous ack.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      OWN0: begin
        wb_cyc_o = m0_cyc_i;
        wb_stb_o = m0_stb_i;
        wb_we_o  = m0_we_i;
        wb_adr_o = m0_adr_i;
        wb_dat_o = m0_dat_i;
        wb_sel_o = m0_sel_i;
        m0_ack_o = wb_ack_i & ~wb_err_i;
        m0_err_o = wb_err_i | wdog_to;
      end
      OWN1: begin
        wb_cyc_o = m1_cyc_i;
        wb_stb_o = m1_stb_i;
        wb_we_o  = m1_we_i;
        wb_adr_o = m1_adr_i;
        wb_dat_o = m1_dat_i;
        wb_sel_o = m1_sel_i;
        m1_ack_o = wb_ack_i & ~wb_err_i;
        m1_err_o = wb_err_i | wdog_to;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;
  assign grant_o  = {state == OWN1, state == OWN0};

`ifdef MMU_ARB_WATCHDOG_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] wdog_cnt;
  logic          stall;

  assign stall = wb_cyc_o & wb_stb_o & ~wb_ack_i & ~wb_err_i;
  // Fires on the TIMEOUT_CYC-th consecutive unterminated strobe cycle.
  assign wdog_to = stall && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (state_nxt == IDLE || wb_ack_i || wb_err_i) begin
      wdog_cnt <= '0;
    end else if (stall) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign wdog_to = 1'b0;
`endif

endmodule

// File: tb/tb_mmu_bus_arb.sv
// Directed bench for mmu_bus_arb: single requester, contention, starvation, locked RMW, reset, watchdog.
`timescale 1ns/1ps
module tb_mmu_bus_arb;

  localparam int unsigned STARVE_MAX  = 4;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_lock;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_wdat, wb_rdat;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic [1:0]  grant;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] exp_g [0:5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};

  mmu_bus_arb #(.STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_wdat), .wb_sel_o(wb_sel),
    .wb_dat_i(wb_rdat), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_all;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0; m0_adr = '0; m0_wdat = '0; m0_sel = 4'hF;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = 4'hF;
    wb_ack = 0; wb_err = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    wb_rdat = '0;
    idle_all();
    repeat (3) tick();
    smp();
    chk("rst_grant", grant, 0);
    chk("rst_wb_cyc", wb_cyc, 0);
    chk("rst_wb_stb", wb_stb, 0);
    chk("rst_wb_adr", wb_adr, 0);
    chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    tick();
    rst_n = 1'b1;

    // CPU path alone, two wait states
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_1000;
    smp(); chk("t1_cyc_not_yet", wb_cyc, 0);
    tick(); smp();
    chk("t1_grant", grant, 2);
    chk("t1_wb_cyc", wb_cyc, 1);
    chk("t1_wb_adr", wb_adr, 32'h0000_1000);
    chk("t1_wait1_ack", m1_ack, 0);
    tick(); smp(); chk("t1_wait2_ack", m1_ack, 0);
    tick(); wb_ack = 1; wb_rdat = 32'hDEAD_BEEF;
    smp();
    chk("t1_ack", m1_ack, 1);
    chk("t1_rdat", m1_rdat, 32'hDEAD_BEEF);
    chk("t1_m0_ack", m0_ack, 0);
    tick(); wb_ack = 0; m1_cyc = 0; m1_stb = 0;
    smp(); chk("t1_ack_one_cycle", m1_ack, 0);
    tick(); smp(); chk("t1_release", grant, 0);

    // Simultaneous request; m0 drops cyc together with its ack
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200;
    smp(); chk("t2_idle", grant, 0);
    tick(); smp();
    chk("t2_grant0", grant, 1);
    chk("t2_adr0", wb_adr, 32'h0000_0100);
    tick(); wb_ack = 1; m0_cyc = 0; m0_stb = 0;
    smp();
    chk("t2_ack0", m0_ack, 1);
    chk("t2_no_ack1", m1_ack, 0);
    chk("t2_cyc_follows", wb_cyc, 0);
    tick(); wb_ack = 0;
    smp(); chk("t2_turnaround", grant, 0);
    tick(); smp();
    chk("t2_grant1", grant, 2);
    chk("t2_adr1", wb_adr, 32'h0000_0200);
    tick(); wb_ack = 1; m1_cyc = 0; m1_stb = 0;
    smp(); chk("t2_ack1", m1_ack, 1);
    tick(); wb_ack = 0;
    smp(); chk("t2_idle_end", grant, 0);

    // Starvation: m1 requests continuously while m0 issues back-to-back reads
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int r = 0; r < 6; r++) begin
      tick(); smp();
      chk($sformatf("t3_grant%0d", r), grant, exp_g[r]);
      tick(); wb_ack = 1;
      if (exp_g[r] == 2'd1) begin
        m0_cyc = 0; m0_stb = 0;
      end else begin
        m1_cyc = 0; m1_stb = 0;
      end
      smp();
      chk($sformatf("t3_acks%0d", r), {m1_ack, m0_ack}, exp_g[r]);
      tick(); wb_ack = 0;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      smp();
      chk($sformatf("t3_gap%0d", r), grant, 0);
    end
    idle_all();
    tick(); smp(); chk("t3_idle", grant, 0);

    // Locked RMW by the walker with m1 waiting
    m0_cyc = 1; m0_stb = 1; m0_lock = 1; m0_adr = 32'h0000_2000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0300;
    tick(); smp();
    chk("t4_grant", grant, 1);
    chk("t4_rd_adr", wb_adr, 32'h0000_2000);
    tick(); wb_ack = 1; wb_rdat = 32'h1234_5678;
    smp();
    chk("t4_rd_ack", m0_ack, 1);
    chk("t4_rd_dat", m0_rdat, 32'h1234_5678);
    chk("t4_rd_no_ack1", m1_ack, 0);
    tick(); wb_ack = 0; m0_cyc = 0; m0_stb = 0;
    smp();
    chk("t4_gap_grant", grant, 1);
    chk("t4_gap_cyc", wb_cyc, 0);
    tick(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_2008; m0_wdat = 32'hCAFE_F00D;
    smp();
    chk("t4_wr_grant", grant, 1);
    chk("t4_wr_we", wb_we, 1);
    chk("t4_wr_adr", wb_adr, 32'h0000_2008);
    chk("t4_wr_dat", wb_wdat, 32'hCAFE_F00D);
    tick(); wb_ack = 1; m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0;
    smp();
    chk("t4_wr_ack", m0_ack, 1);
    chk("t4_wr_no_ack1", m1_ack, 0);
    tick(); wb_ack = 0;
    smp(); chk("t4_released", grant, 0);
    tick(); smp();
    chk("t4_m1_grant", grant, 2);
    chk("t4_m1_adr", wb_adr, 32'h0000_0300);
    tick(); wb_ack = 1; wb_err = 1;
    smp();
    chk("t4_err_wins", {m1_err, m1_ack}, 2'b10);
    chk("t4_m0_err", m0_err, 0);
    tick(); wb_ack = 0; wb_err = 0; m1_cyc = 0; m1_stb = 0;
    smp(); chk("t4_still_own1", grant, 2);
    tick(); smp(); chk("t4_idle", grant, 0);

    // Reset during an m1 wait state
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_1000;
    tick(); smp();
    chk("t5_grant", grant, 2);
    tick(); rst_n = 0;
    smp(); chk("t5_wait_ack", m1_ack, 0);
    tick(); wb_ack = 1;
    smp();
    chk("t5_rst_cyc", wb_cyc, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_no_ack", m1_ack, 0);
    tick(); rst_n = 1; wb_ack = 0;
    smp(); chk("t5_post_rst", grant, 0);
    tick(); smp(); chk("t5_regrant", grant, 2);
    tick(); wb_ack = 1; wb_rdat = 32'h55AA_55AA; m1_cyc = 0; m1_stb = 0;
    smp();
    chk("t5_ack", m1_ack, 1);
    chk("t5_dat", m1_rdat, 32'h55AA_55AA);
    tick(); wb_ack = 0;
    smp(); chk("t5_idle", grant, 0);

`ifdef MMU_ARB_WATCHDOG_EN
    begin
      int i;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_4000;
      m1_cyc = 1; m1_stb = 1;
      tick(); smp();
      chk("t6_grant", grant, 1);
      i = 1;
      while (!m0_err && i < 20) begin
        tick(); smp();
        i++;
      end
      chk("t6_err_cycle", m0_err ? i : 0, TIMEOUT_CYC);
      tick(); m0_cyc = 0; m0_stb = 0;
      smp();
      chk("t6_forced_idle", grant, 0);
      chk("t6_err_pulse", m0_err, 0);
      tick(); smp(); chk("t6_m1_grant", grant, 2);
      tick(); m1_cyc = 0; m1_stb = 0;
      tick(); smp(); chk("t6_idle", grant, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmu_bus_arb.md
Name: mmu_bus_arb

Overview:
- Arbiter for the PMMU's single external Wishbone classic master port.
- Requester 0 is the table-walk engine, which issues descriptor fetches and locked read-modify-write cycles for U/M bit updates.
- Requester 1 is the translated CPU access path.
- The arbiter sequences ownership, routes cycle termination back to the owner, and prevents starvation of the CPU path during long walks.

Parameters:
- STARVE_MAX, 4: number of consecutive requester-0 grants allowed while requester 1 waits; the next grant then goes to requester 1.
- TIMEOUT_CYC, 255: bus-cycle watchdog limit in clocks (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  walker cycle, strobe, write
- m0_lock_i  in  1  walker keeps ownership across cycles (RMW)
- m0_adr_i  in  32  walker address
- m0_dat_i  in  32  walker write data
- m0_sel_i  in  4  walker byte select
- m0_dat_o  out  32  walker read data
- m0_ack_o, m0_err_o  out  1 each  walker termination
- m1_cyc_i, m1_stb_i, m1_we_i  in  1 each  CPU path cycle, strobe, write
- m1_adr_i  in  32  CPU path address
- m1_dat_i  in  32  CPU path write data
- m1_sel_i  in  4  CPU path byte select
- m1_dat_o  out  32  CPU path read data
- m1_ack_o, m1_err_o  out  1 each  CPU path termination
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  bus cycle, strobe, write
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  bus write data
- wb_sel_o  out  4  bus byte select
- wb_dat_i  in  32  bus read data
- wb_ack_i, wb_err_i  in  1 each  bus termination
- grant_o  out  2  one-hot current owner; 00 when idle

Behaviour:
- Reset (rst_n=0 at clock edge):
  - state=IDLE, grant_o=00, starvation counter=0, watchdog=0.
  - All wb_* outputs and m*_ack_o/m*_err_o are 0.
  - A reset mid-transaction drops wb_cyc_o on the following edge and produces no termination to either master.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Arbitration uses m0_cyc_i and m1_cyc_i sampled this cycle.
  - Only one requesting -> that requester wins.
  - Both requesting -> requester 0 wins, unless starvation counter = STARVE_MAX, in which case requester 1 wins.
  - Neither requesting -> remain in IDLE.
  - The grant is registered, so the bus sees the cycle one clock after cyc_i rises.
- OWNn:
  - wb_cyc_o = mn_cyc_i; wb_stb_o = mn_stb_i.
  - wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o are driven combinationally from mn.
  - mn_ack_o = wb_ack_i and mn_err_o = wb_err_i.
  - The non-owner's ack and err are held 0; both m*_dat_o = wb_dat_i.
- Release and re-arbitration:
  - OWN1 -> IDLE when m1_cyc_i=0.
  - OWN0 -> IDLE when m0_cyc_i=0 and m0_lock_i=0.
  - While m0_lock_i=1, OWN0 holds even if m0_cyc_i drops between read and write; wb_cyc_o follows m0_cyc_i.
  - No direct OWN0<->OWN1 transition; IDLE always lasts one cycle. This gives a one-cycle bus turnaround.
- Starvation counter (saturating, range 0..STARVE_MAX):
  - Increment on each IDLE->OWN0 grant made while m1_cyc_i=1.
  - Clear on any IDLE->OWN1 grant.
  - Clear when m1_cyc_i=0 in IDLE.
- Simultaneous events:
  - wb_ack_i and wb_err_i both high -> err takes precedence; ack is suppressed to the owner.
  - The owner dropping cyc_i in the same cycle as the ack -> ack is delivered, and the release occurs on that edge.
- grant_o reflects the registered state: OWN0=01, OWN1=10.

Optional Feature:
- Macro: MMU_ARB_WATCHDOG_EN.
- With the macro defined:
  - Watchdog counts clocks while wb_cyc_o&wb_stb_o and neither wb_ack_i nor wb_err_i is asserted; it resets on any termination or when leaving OWNn.
  - At count = TIMEOUT_CYC, the owner's err_o is pulsed for one cycle.
  - The state is then forced to IDLE regardless of lock.
  - The owner must drop cyc_i; the other requester may win on the next arbitration.
- Without the macro: no counter logic; a hung slave holds ownership indefinitely.

Test Plan:
- Requester 1 alone, read at adr 0x0000_1000; slave acks with 0xDEADBEEF after 2 waits -> wb_cyc_o rises 1 clock after m1_cyc_i, m1_dat_o=0xDEADBEEF with m1_ack_o for 1 cycle, grant_o returns to 00.
- m0 and m1 both assert cyc_i in the same cycle from IDLE -> grant_o=01 first; m1 is served after m0 releases plus one IDLE cycle.
- m0 issues 5 back-to-back single reads with m1 continuously requesting, STARVE_MAX=4 -> grants are 01,01,01,01,10 then 01; the counter clears after the OWN1 grant.
- m0 locked RMW: read 0x0000_2000, cyc drops for 1 cycle with lock=1, write 0x0000_2008; m1 requests throughout -> grant_o stays 01 until lock and cyc are both 0; m1_ack_o is never asserted meanwhile.
- rst_n=0 asserted mid-way through an m1 wait state -> next edge: wb_cyc_o=0, grant_o=00, no m1_ack_o; after release m1 re-arbitrates normally.
- MMU_ARB_WATCHDOG_EN, TIMEOUT_CYC=8, slave never responds to m0 -> m0_err_o pulses at cycle 8 of the stall, state goes to IDLE, and a pending m1 is granted next.
